kb_axi4lite_slave_regs: RTL and testbench
=========================================

// Module: kb_axi4lite_slave_regs
// PURPOSE
//  AXI4-Lite responder (slave) holding NUM_REGS 32-bit registers, driven by the kb_axi4lite agent.
//  - Independent AW/W capture, byte-strobed writes, one outstanding read and one outstanding write.
//  - Read-only slots mirror fabric status inputs.
//  - Sits between the PS/agent AXI4-Lite bus and PL control/status logic.
// PARAMETERS
//  NUM_REGS   8       number of 32-bit registers, 1..16; byte address range 0 .. 4*NUM_REGS-1
//  RO_MASK    8'h80   NUM_REGS bits; bit i=1 -> reg i read-only (reads ro_data_i slice i)
//  RESET_VAL  32'h0   reset value of every read-write register
// PORTS
//  ACLK        in   1            clock, all logic on rising edge
//  ARESETn     in   1            asynchronous active-low reset
//  AWADDR      in   32           write byte address
//  AWPROT      in   3            ignored
//  AWVALID     in   1            write address valid
//  AWREADY     out  1            write address ready
//  WDATA       in   32           write data
//  WSTRB       in   4            write byte strobes; bit b enables WDATA[8b+7:8b]
//  WVALID      in   1            write data valid
//  WREADY      out  1            write data ready
//  BRESP       out  2            2'b00 OKAY, 2'b10 SLVERR
//  BVALID      out  1            write response valid
//  BREADY      in   1            write response ready
//  ARADDR      in   32           read byte address
//  ARPROT      in   3            ignored
//  ARVALID     in   1            read address valid
//  ARREADY     out  1            read address ready
//  RDATA       out  32           read data
//  RRESP       out  2            2'b00 OKAY, 2'b10 SLVERR
//  RVALID      out  1            read data valid
//  RREADY      in   1            read data ready
//  reg_o       out  32*NUM_REGS  register contents, reg i at [32i+31:32i]
//  ro_data_i   in   32*NUM_REGS  status values; only slices with RO_MASK[i]=1 are used
//  wr_pulse_o  out  NUM_REGS     1-cycle pulse on bit i when reg i is committed (OKAY writes only)
// BEHAVIOUR
//  Reset (async assert, sync release): all ready/valid outputs 0, BRESP/RRESP/RDATA 0,
//   RW regs = RESET_VAL, wr_pulse_o 0, both FSMs idle, held flags cleared.
//   First edge after release: AWREADY=WREADY=ARREADY=1.
//  Reset mid-transaction: the outstanding transaction is dropped; no response is issued.
//  Address decode: idx = ADDR[5:2]; valid iff ADDR < 4*NUM_REGS. ADDR[1:0] is ignored.
//  All outputs are registered.
//  Write FSM WR_IDLE / WR_RESP:
//   - WR_IDLE, AW channel: AWREADY=1 while AW is not held. AWVALID&AWREADY latches AWADDR, sets aw_held,
//     drops AWREADY.
//   - WR_IDLE, W channel: identically latches WDATA/WSTRB, sets w_held, drops WREADY. AW and W may arrive
//     in any order or the same cycle.
//   - Commit edge (first edge with aw_held&w_held):
//     - valid RW address: strobed bytes are merged into reg idx; wr_pulse_o[idx]=1 for that cycle;
//       BRESP=OKAY.
//     - out-of-range or RO address: no register change, no pulse, BRESP=SLVERR.
//     - BVALID=1; held flags cleared; go to WR_RESP.
//     - Latency: both captured at edge N -> reg_o/BVALID updated at edge N+1.
//   - WSTRB=0 to a valid RW reg: OKAY with wr_pulse, data unchanged.
//   - WR_RESP: BVALID and BRESP stable until BREADY. On BVALID&BREADY: BVALID=0, AWREADY=WREADY=1,
//     go to WR_IDLE. AW/W are not accepted in WR_RESP.
//  Read FSM RD_IDLE / RD_RESP:
//   - RD_IDLE: ARREADY=1. On ARVALID&ARREADY at edge N:
//     - RDATA = reg idx (or ro_data_i slice if RO), sampled at edge N.
//     - RRESP=OKAY; out-of-range gives RDATA=0, RRESP=SLVERR.
//     - RVALID=1 and ARREADY=0 after edge N; go to RD_RESP.
//   - RD_RESP: RDATA/RRESP/RVALID stable until RREADY. On RVALID&RREADY: RVALID=0, ARREADY=1, go to RD_IDLE.
//     RDATA holds its last value.
//  Read and write paths are fully independent. A read accepted on the same edge as a write commit to the
//   same reg returns the pre-write value.
// TESTING
//  1 Reset release -> all VALIDs 0; AWREADY/WREADY/ARREADY=1 after first edge; reg_o all 32'h0.
//  2 AW=0x8 with W=0xDEADBEEF, STRB=4'hF same cycle, BREADY=1 -> reg_o[2]=0xDEADBEEF and wr_pulse_o=8'h04
//    one edge later, BRESP=OKAY.
//  3 W first (0x000000AA, STRB=4'h1), AW=0x4 three cycles later, reg1 was 0x11223344 -> reg1=0x112233AA;
//    BVALID held 5 cycles with BREADY=0, then ready.
//  4 Write 0x1C (RO reg 7) and 0x40 (out of range) -> BRESP=SLVERR, no reg change, no wr_pulse.
//    Read 0x40 -> RDATA=0, RRESP=SLVERR.
//  5 ro_data_i[7]=0xCAFE0001, read 0x1F with RREADY low 3 cycles -> RDATA=0xCAFE0001, RRESP=OKAY,
//    stable until handshake; ARREADY low throughout.
//  6 ARESETn asserted while BVALID=1 and reg3=0x55 -> BVALID=0 immediately, reg3=RESET_VAL;
//    after release no stale response.

Source files
------------

// File: rtl/kb_axi4lite_slave_regs.sv
// AXI4-Lite responder with NUM_REGS 32-bit registers. Read-only slots mirror
// ro_data_i; every bus output is a flop. Write and read paths are independent.
module kb_axi4lite_slave_regs #(
  parameter int unsigned          NUM_REGS  = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = 8'h80,
  parameter logic [31:0]          RESET_VAL = 32'h0
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [31:0]              AWADDR,
  input  logic [2:0]               AWPROT,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [31:0]              ARADDR,
  input  logic [2:0]               ARPROT,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [32*NUM_REGS-1:0]   reg_o,
  input  logic [32*NUM_REGS-1:0]   ro_data_i,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * NUM_REGS);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t wr_state, wr_state_d;
  rd_state_t rd_state, rd_state_d;

  logic        aw_held, aw_held_d, w_held, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  logic [1:0]  bresp_d, rresp_d;
  logic [31:0] rdata_d;
  logic [NUM_REGS-1:0] wr_pulse_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic        wr_rw_hit;

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  // Pack register storage onto the flat output bus.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign reg_o[32*g +: 32] = regs_q[g];
  end

  // Write path next-state: independent AW/W capture, commit once both are held.
  always_comb begin
    wr_state_d = wr_state;
    aw_held_d  = aw_held;
    w_held_d   = w_held;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = AWREADY;
    wready_d   = WREADY;
    bvalid_d   = BVALID;
    bresp_d    = BRESP;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    wr_rw_hit  = 1'b0;
    if (awaddr_q < ADDR_LIMIT) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (awaddr_q[5:2] == 4'(i) && !RO_MASK[i]) wr_rw_hit = 1'b1;
      end
    end
    case (wr_state)
      WR_IDLE: begin
        if (aw_held && w_held) begin
          if (wr_rw_hit) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (awaddr_q[5:2] == 4'(i)) begin
                wr_pulse_d[i] = 1'b1;
                for (int unsigned b = 0; b < 4; b++) begin
                  if (wstrb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                end
              end
            end
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
          bvalid_d   = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          wr_state_d = WR_RESP;
        end else begin
          if (AWVALID && AWREADY) begin
            awaddr_d  = AWADDR;
            aw_held_d = 1'b1;
            awready_d = 1'b0;
          end else begin
            awready_d = !aw_held;
          end
          if (WVALID && WREADY) begin
            wdata_d  = WDATA;
            wstrb_d  = WSTRB;
            w_held_d = 1'b1;
            wready_d = 1'b0;
          end else begin
            wready_d = !w_held;
          end
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Write path state and registered outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state   <= WR_IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      AWREADY    <= 1'b0;
      WREADY     <= 1'b0;
      BVALID     <= 1'b0;
      BRESP      <= '0;
      wr_pulse_o <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      wr_state   <= wr_state_d;
      aw_held    <= aw_held_d;
      w_held     <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      AWREADY    <= awready_d;
      WREADY     <= wready_d;
      BVALID     <= bvalid_d;
      BRESP      <= bresp_d;
      wr_pulse_o <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  // Read path next-state: data sampled from current (pre-commit) register values.
  always_comb begin
    rd_state_d = rd_state;
    arready_d  = ARREADY;
    rvalid_d   = RVALID;
    rdata_d    = RDATA;
    rresp_d    = RRESP;
    case (rd_state)
      RD_IDLE: begin
        if (ARVALID && ARREADY) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          if (ARADDR < ADDR_LIMIT) begin
            rresp_d = RESP_OKAY;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (ARADDR[5:2] == 4'(i)) rdata_d = RO_MASK[i] ? ro_data_i[32*i +: 32] : regs_q[i];
            end
          end
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = RD_RESP;
        end else begin
          arready_d = 1'b1;
        end
      end
      RD_RESP: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read path state and registered outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state <= RD_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RRESP    <= '0;
    end else begin
      rd_state <= rd_state_d;
      ARREADY  <= arready_d;
      RVALID   <= rvalid_d;
      RDATA    <= rdata_d;
      RRESP    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_kb_axi4lite_slave_regs.sv
// Directed bench for kb_axi4lite_slave_regs (default parameters).
module tb_kb_axi4lite_slave_regs;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [255:0] reg_o;
  logic [255:0] ro_data = '0;
  logic [7:0]   wr_pulse;

  int total = 0;
  int bad = 0;

  kb_axi4lite_slave_regs #(.NUM_REGS(8), .RO_MASK(8'h80), .RESET_VAL(32'h0)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
    .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
    .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready),
    .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
    .reg_o(reg_o), .ro_data_i(ro_data), .wr_pulse_o(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write with AW and W together, BREADY high; reports response and pulse seen with BVALID.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [7:0] pulse);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin step(); n++; end
    total++;
    if (!bvalid) begin
      bad++;
      $display("FAIL write_timeout addr=%h got bvalid=%b want 1", a, bvalid);
    end
    resp = bresp; pulse = wr_pulse;
    step();
  endtask

  // Full read with RREADY high; reports data and response.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin step(); n++; end
    total++;
    if (!rvalid) begin
      bad++;
      $display("FAIL read_timeout addr=%h got rvalid=%b want 1", a, rvalid);
    end
    d = rdata; resp = rresp;
    step();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || wr_pulse !== 8'h0) begin
      bad++;
      $display("FAIL reset_hold got rdy/vld=%b pulse=%h want 0", {awready, wready, arready, bvalid, rvalid}, wr_pulse);
    end
    rst_n = 1'b1;
    step();
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      bad++;
      $display("FAIL reset_release got %b want 11100", {awready, wready, arready, bvalid, rvalid});
    end
    total++;
    if (reg_o !== 256'h0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_values got reg_o=%h rdata=%h want 0", reg_o, rdata);
    end
  endtask

  task automatic test_write_same_cycle();
    awaddr = 32'h8; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    total++;
    if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || reg_o[64 +: 32] !== 32'h0) begin
      bad++;
      $display("FAIL wr_capture got awr=%b wr=%b bv=%b reg2=%h want 0 0 0 0", awready, wready, bvalid, reg_o[64 +: 32]);
    end
    step();
    total++;
    if (reg_o[64 +: 32] !== 32'hDEADBEEF || wr_pulse !== 8'h04 || bvalid !== 1'b1 || bresp !== 2'b00) begin
      bad++;
      $display("FAIL wr_commit got reg2=%h pulse=%h bv=%b bresp=%b want deadbeef 04 1 00",
               reg_o[64 +: 32], wr_pulse, bvalid, bresp);
    end
    step();
    total++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || wr_pulse !== 8'h0) begin
      bad++;
      $display("FAIL wr_bhandshake got bv=%b awr=%b wr=%b pulse=%h want 0 1 1 00", bvalid, awready, wready, wr_pulse);
    end
  endtask

  task automatic test_write_w_first();
    logic [1:0] r;
    logic [7:0] p;
    do_write(32'h4, 32'h11223344, 4'hF, r, p);
    total++;
    if (reg_o[32 +: 32] !== 32'h11223344 || r !== 2'b00 || p !== 8'h02) begin
      bad++;
      $display("FAIL wr_reg1_init got reg1=%h resp=%b pulse=%h want 11223344 00 02", reg_o[32 +: 32], r, p);
    end
    bready = 1'b0;
    wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    step();
    step();
    total++;
    if (bvalid !== 1'b0 || wready !== 1'b0 || awready !== 1'b1) begin
      bad++;
      $display("FAIL wfirst_wait got bv=%b wr=%b awr=%b want 0 0 1", bvalid, wready, awready);
    end
    awaddr = 32'h4; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    step();
    total++;
    if (reg_o[32 +: 32] !== 32'h112233AA || wr_pulse !== 8'h02 || bvalid !== 1'b1 || bresp !== 2'b00) begin
      bad++;
      $display("FAIL wfirst_commit got reg1=%h pulse=%h bv=%b want 112233aa 02 1", reg_o[32 +: 32], wr_pulse, bvalid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        bad++;
        $display("FAIL bvalid_hold cyc=%0d got bv=%b bresp=%b awr=%b want 1 00 0", i, bvalid, bresp, awready);
      end
    end
    bready = 1'b1;
    step();
    total++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      bad++;
      $display("FAIL bvalid_release got bv=%b awr=%b want 0 1", bvalid, awready);
    end
  endtask

  task automatic test_error_responses();
    logic [1:0]   r;
    logic [7:0]   p;
    logic [31:0]  d;
    logic [255:0] snap;
    snap = '0;
    snap[32 +: 32] = 32'h112233AA;
    snap[64 +: 32] = 32'hDEADBEEF;
    do_write(32'h1C, 32'h12345678, 4'hF, r, p);
    total++;
    if (r !== 2'b10 || p !== 8'h00 || reg_o !== snap) begin
      bad++;
      $display("FAIL wr_ro got resp=%b pulse=%h reg7=%h want 10 00 0", r, p, reg_o[224 +: 32]);
    end
    do_write(32'h40, 32'h87654321, 4'hF, r, p);
    total++;
    if (r !== 2'b10 || p !== 8'h00 || reg_o !== snap) begin
      bad++;
      $display("FAIL wr_oor got resp=%b pulse=%h want 10 00 regs unchanged", r, p);
    end
    do_read(32'h8, d, r);
    total++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      bad++;
      $display("FAIL rd_reg2 got %h/%b want deadbeef/00", d, r);
    end
    do_read(32'h40, d, r);
    total++;
    if (d !== 32'h0 || r !== 2'b10) begin
      bad++;
      $display("FAIL rd_oor got %h/%b want 00000000/10", d, r);
    end
  endtask

  task automatic test_ro_read();
    ro_data[224 +: 32] = 32'hCAFE0001;
    araddr = 32'h1F; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    ro_data[224 +: 32] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rvalid !== 1'b1 || rdata !== 32'hCAFE0001 || rresp !== 2'b00 || arready !== 1'b0) begin
        bad++;
        $display("FAIL ro_hold cyc=%0d got rv=%b rdata=%h rresp=%b arr=%b want 1 cafe0001 00 0",
                 i, rvalid, rdata, rresp, arready);
      end
      step();
    end
    rready = 1'b1;
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL ro_before_ready got rv=%b rdata=%h want 1 cafe0001", rvalid, rdata);
    end
    step();
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || rdata !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL ro_handshake got rv=%b arr=%b rdata=%h want 0 1 cafe0001", rvalid, arready, rdata);
    end
  endtask

  task automatic test_read_during_write();
    awaddr = 32'h8; wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h8; arvalid = 1'b1; rready = 1'b1;
    step();
    arvalid = 1'b0;
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || reg_o[64 +: 32] !== 32'h01020304 || bvalid !== 1'b1) begin
      bad++;
      $display("FAIL rd_same_edge got rv=%b rdata=%h reg2=%h bv=%b want 1 deadbeef 01020304 1",
               rvalid, rdata, reg_o[64 +: 32], bvalid);
    end
    step();
    total++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
      bad++;
      $display("FAIL rd_wr_done got rv=%b bv=%b want 0 0", rvalid, bvalid);
    end
  endtask

  task automatic test_reset_mid_txn();
    logic [1:0] r;
    logic [7:0] p;
    do_write(32'hC, 32'h55, 4'hF, r, p);
    total++;
    if (reg_o[96 +: 32] !== 32'h55 || r !== 2'b00) begin
      bad++;
      $display("FAIL wr_reg3 got reg3=%h resp=%b want 00000055 00", reg_o[96 +: 32], r);
    end
    bready = 1'b0;
    awaddr = 32'h10; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    total++;
    if (bvalid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_bvalid got %b want 1", bvalid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bvalid !== 1'b0 || reg_o !== 256'h0 || awready !== 1'b0 || wr_pulse !== 8'h0) begin
      bad++;
      $display("FAIL async_reset got bv=%b reg3=%h awr=%b want 0 0 0", bvalid, reg_o[96 +: 32], awready);
    end
    bready = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0 || reg_o !== 256'h0) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got bv=%b rv=%b reg4=%h want 0 0 0", i, bvalid, rvalid, reg_o[128 +: 32]);
      end
    end
    total++;
    if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_ready got %b%b%b want 111", awready, wready, arready);
    end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_write_w_first();
    test_error_responses();
    test_ro_read();
    test_read_during_write();
    test_reset_mid_txn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
